// File: rtl/flit_deserializer_pkg.sv
// Shared flit, UART and status types plus the checksum helpers used by the
// serializer and the deserializer.
package flit_deserializer_pkg;

    localparam int unsigned FLIT_WIDTH = 128;
    localparam int unsigned FLIT_BYTES = FLIT_WIDTH / 8;

    typedef logic [FLIT_WIDTH-1:0] flit_t;
    typedef logic [7:0]            uart_data_t;
    typedef logic [15:0]           checksum_t;

    typedef enum logic [31:0] {
        NO_ERROR           = 32'd0,
        RX_BUFFER_OVERFLOW = 32'd1
    } signal_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StCheck
    } deser_state_t;

    // One ones'-complement addition step with end-around carry.
    function automatic checksum_t checksum_add(checksum_t acc, logic [15:0] word);
        logic [16:0] sum;
        sum = {1'b0, acc} + {1'b0, word};
        // Max sum is 17'h1FFFE, so folding the carry back in cannot carry again.
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

    // Inverted ones'-complement sum over the seven header/data words.
    function automatic checksum_t checksum_calc(logic [111:0] data);
        checksum_t acc;
        acc = '0;
        for (int i = 0; i < 7; i++) begin
            acc = checksum_add(acc, data[111 - 16 * i -: 16]);
        end
        return ~acc;
    endfunction

endpackage

// File: rtl/flit_deserializer_hold.sv
// Single-entry valid/ready holding register. A commit loads when the entry is
// free or being drained this cycle; otherwise the new flit is dropped.
module flit_hold_reg
    import flit_deserializer_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  commit,
    input  flit_t commit_data,
    input  logic  ready,
    output flit_t data,
    output logic  valid,
    output logic  load,
    output logic  drop
);

    flit_t data_q;
    logic  valid_q;
    logic  valid_d;

    assign load  = commit && (!valid_q || ready);
    assign drop  = commit && valid_q && !ready;
    assign data  = data_q;
    assign valid = valid_q;

    // Occupancy: a load wins over a same-cycle drain.
    always_comb begin
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage; data only changes on a load so it is stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= commit_data;
            end
        end
    end

endmodule

// File: rtl/flit_deserializer.sv
// Rebuilds 128-bit flits from the UART byte stream (MSB first), verifies the
// trailing 16-bit checksum and hands good flits to a one-entry holding register.
module flit_deserializer
    import flit_deserializer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  uart_data_t           rx_data,
    input  logic                 rx_valid,
    output flit_t                flit_out,
    output logic                 flit_valid,
    input  logic                 flit_ready,
    output logic                 checksum_err,
    output logic                 timeout_err,
    output signal_t              status,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] bad_cnt
);

    localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmoWidth-1:0]  TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);
    localparam logic [TmoWidth-1:0]  TmoOne  = 1;
    localparam logic [CNT_WIDTH-1:0] CntOne  = 1;
    localparam logic [3:0]           IdxLast = 4'(FLIT_BYTES - 1);

    deser_state_t         state_q, state_d;
    logic [3:0]           idx_q;
    flit_t                shreg_q;
    checksum_t            acc_q;
    uart_data_t           prev_q;
    logic [TmoWidth-1:0]  tcnt_q;
    logic [6:0]           byte_lsb;
    logic                 cs_pass, cs_fail, tmo;
    logic                 hold_load, hold_drop;
    logic                 checksum_err_q, timeout_err_q;
    signal_t              status_q;
    logic [CNT_WIDTH-1:0] good_cnt_q, bad_cnt_q;

    assign byte_lsb = 7'd120 - {idx_q, 3'b000};

    // Next state plus the one-cycle check and timeout decisions.
    always_comb begin
        state_d = state_q;
        cs_pass = 1'b0;
        cs_fail = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) state_d = StCollect;
            end
            StCollect: begin
                if (rx_valid) begin
                    if (idx_q == IdxLast) state_d = StCheck;
                end else if (tcnt_q == TmoLast) begin
                    tmo     = 1'b1;
                    state_d = StIdle;
                end
            end
            StCheck: begin
                if (~acc_q == shreg_q[15:0]) cs_pass = 1'b1;
                else                         cs_fail = 1'b1;
                // A byte strobed here is byte 0 of the next flit.
                state_d = rx_valid ? StCollect : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Byte capture, incremental checksum and idle timer; never stalls rx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            prev_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            if (rx_valid) begin
                prev_q <= rx_data;
                if (state_q == StCollect) begin
                    shreg_q[byte_lsb +: 8] <= rx_data;
                    idx_q                  <= idx_q + 4'd1;
                    // Odd index completes a word; bytes 14/15 are the checksum field.
                    if (idx_q[0] && idx_q != IdxLast) begin
                        acc_q <= checksum_add(acc_q, {prev_q, rx_data});
                    end
                end else begin
                    shreg_q[127:120] <= rx_data;
                    idx_q            <= 4'd1;
                    acc_q            <= '0;
                end
            end
            if (state_q == StCollect && !rx_valid && tcnt_q != TmoLast) begin
                tcnt_q <= tcnt_q + TmoOne;
            end else begin
                tcnt_q <= '0;
            end
        end
    end

    flit_hold_reg u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit      (cs_pass),
        .commit_data (shreg_q),
        .ready       (flit_ready),
        .data        (flit_out),
        .valid       (flit_valid),
        .load        (hold_load),
        .drop        (hold_drop)
    );

    // Error pulses, status code and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_err_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            status_q       <= NO_ERROR;
            good_cnt_q     <= '0;
            bad_cnt_q      <= '0;
        end else begin
            checksum_err_q <= cs_fail;
            timeout_err_q  <= tmo;
            status_q       <= hold_drop ? RX_BUFFER_OVERFLOW : NO_ERROR;
            if (hold_load && good_cnt_q != '1) begin
                good_cnt_q <= good_cnt_q + CntOne;
            end
            // Drop causes are mutually exclusive within a cycle.
            if ((cs_fail || tmo || hold_drop) && bad_cnt_q != '1) begin
                bad_cnt_q <= bad_cnt_q + CntOne;
            end
        end
    end

    assign checksum_err = checksum_err_q;
    assign timeout_err  = timeout_err_q;
    assign status       = status_q;
    assign good_cnt     = good_cnt_q;
    assign bad_cnt      = bad_cnt_q;

endmodule
